// File: rtl/dense_layer_sequencer_if.sv
// Codec sample bus and weight ROM port for the dense layer sequencer.
// The slave modport is the sequencer's view; the master modport is the codec/ROM side.
interface dense_layer_sequencer_if #(
  parameter int W = 16
);
  logic                sample_clk;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;
  logic [7:0]          jack;
  logic [3:0]          weight_addr;
  logic signed [W-1:0] weight_data;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;
  logic                busy;
  logic                overrun;

  modport master (
    output sample_clk, sample_in0, sample_in1, sample_in2, sample_in3, jack, weight_data,
    input  weight_addr, sample_out0, sample_out1, sample_out2, sample_out3, busy, overrun
  );

  modport slave (
    input  sample_clk, sample_in0, sample_in1, sample_in2, sample_in3, jack, weight_data,
    output weight_addr, sample_out0, sample_out1, sample_out2, sample_out3, busy, overrun
  );
endinterface

// File: rtl/dense_layer_sequencer.sv
// 4x4 Q4.12 dense layer over the codec channels: one shared MAC walks a registered-read
// weight ROM, rounds/saturates each row into a shadow bank, then commits all four at once.
module dense_layer_sequencer #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int ACC_W = 36
) (
  input logic                     clk,
  input logic                     rst,
  dense_layer_sequencer_if.slave  bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, MAC = 1'b1} state_t;

  localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t                  state_r;
  logic [4:0]              step_r;
  logic                    sclk_q_r;
  logic signed [W-1:0]     x_r      [4];
  logic signed [W-1:0]     shadow_r [4];
  logic signed [W-1:0]     out_r    [4];
  logic signed [ACC_W-1:0] acc_r;
  logic [3:0]              addr_r;
  logic                    busy_r;
  logic                    overrun_r;

  logic                    rise_s;
  logic [3:0]              k_s;
  logic signed [W-1:0]     in_s     [4];
  logic signed [2*W-1:0]   product_s;
  logic signed [ACC_W-1:0] sum_s;
  logic                    unused_jack_s;

  // Round half toward +inf, then clamp into the W-bit signed range.
  function automatic logic signed [W-1:0] round_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = (v + HALF) >>> FRAC;
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end else begin
      r = r;
    end
    return r[W-1:0];
  endfunction

  assign unused_jack_s = ^bus.jack[7:4];

  // Start detect, product index decode and the MAC datapath.
  always_comb begin
    rise_s    = bus.sample_clk & ~sclk_q_r;
    in_s[0]   = bus.sample_in0;
    in_s[1]   = bus.sample_in1;
    in_s[2]   = bus.sample_in2;
    in_s[3]   = bus.sample_in3;
    // Data consumed at step e was addressed at step e-2, so it carries product e-2.
    k_s       = step_r[3:0] - 4'd2;
    product_s = bus.weight_data * x_r[k_s[1:0]];
    sum_s     = acc_r + ACC_W'(product_s);
  end

  // Sequencer state, accumulator, shadow bank and committed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      step_r    <= 5'd0;
      sclk_q_r  <= 1'b1;
      acc_r     <= '0;
      addr_r    <= 4'd0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_r[i]      <= '0;
        shadow_r[i] <= '0;
        out_r[i]    <= '0;
      end
    end else begin
      sclk_q_r <= bus.sample_clk;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            for (int i = 0; i < 4; i++) begin
              x_r[i] <= bus.jack[i] ? in_s[i] : '0;
            end
            addr_r  <= 4'd0;
            busy_r  <= 1'b1;
            acc_r   <= '0;
            step_r  <= 5'd1;
            state_r <= MAC;
          end
        end
        MAC: begin
          if (rise_s) begin
            overrun_r <= 1'b1;
          end
          step_r <= step_r + 5'd1;
          if (step_r <= 5'd15) begin
            addr_r <= step_r[3:0];
          end
          if ((step_r >= 5'd2) && (step_r <= 5'd17)) begin
            if (k_s[1:0] == 2'd3) begin
              shadow_r[k_s[3:2]] <= round_sat(sum_s);
              acc_r              <= '0;
            end else begin
              acc_r <= sum_s;
            end
          end
          if (step_r == 5'd18) begin
            for (int i = 0; i < 4; i++) begin
              out_r[i] <= shadow_r[i];
            end
            busy_r  <= 1'b0;
            addr_r  <= 4'd0;
            step_r  <= 5'd0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.weight_addr = addr_r;
  assign bus.busy        = busy_r;
  assign bus.overrun     = overrun_r;
  assign bus.sample_out0 = out_r[0];
  assign bus.sample_out1 = out_r[1];
  assign bus.sample_out2 = out_r[2];
  assign bus.sample_out3 = out_r[3];
endmodule

// File: doc/dense_layer_sequencer.md
Name: dense_layer_sequencer

Overview:
Sequences a 4x4 fixed-point dense layer over the four codec sample channels using one shared multiply-accumulate unit and an external weight ROM. On each rising edge of the sample strobe it snapshots the four inputs, walks all 16 weights, and rounds and saturates each output row. It commits all four outputs together. It sits between the codec sample bus and the output jacks, in place of a pass-through core.

Parameters:
W, 16, sample and weight width (signed, two's complement)
FRAC, 12, fractional bits of weights (Q4.12: 4096 = 1.0)
ACC_W, 36, accumulator width (must be >= 2*W+2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_clk  in  1  sample strobe, synchronous to clk; a start is its 0->1 transition
sample_in0..sample_in3  in  W  signed input samples
jack  in  8  jack-detect; bit i=1 means input i is patched (bits 7:4 unused)
weight_addr  out  4  ROM address = row*4 + col (row = output index, col = input index)
weight_data  in  W  signed ROM data; 1-cycle registered read latency
sample_out0..sample_out3  out  W  signed outputs
busy  out  1  high while a computation is in progress
overrun  out  1  sticky; set when a start arrives while busy

Behaviour:
- Reset, asynchronous: sample_out* = 0, weight_addr = 0, busy = 0, overrun = 0, state IDLE, accumulator = 0.
- Reset also sets the sample_clk history flop to 1, so a sample_clk held high across reset release causes no start.
- Start detect: rise = sample_clk & ~sample_clk_q, evaluated every clk edge.
- States: IDLE, MAC.
- Define edge 0 as the clk edge in IDLE where rise = 1. At edge 0:
  - latch x[i] = jack[i] ? sample_in_i : 0
  - weight_addr <= 0, busy <= 1, state <= MAC
- Edges 1..15: weight_addr increments by 1, reaching 15 at edge 15, then holds.
- ROM timing: an address registered at edge n yields data that is consumed at edge n+2.
  - Product k = weight_data * x[k%4], full 2W-bit signed.
  - Products are accumulated at edges 2..17.
- Row finalise, at the edge consuming product k with k%4 == 3:
  - v = acc + product
  - r = (v + 2^(FRAC-1)) >>> FRAC (round half toward +inf)
  - saturate r to [-2^(W-1), 2^(W-1)-1]
  - write the result to shadow[k/4]; clear acc to 0 at the same edge
- Edge 18:
  - sample_out0..3 <= shadow0..3 simultaneously
  - busy <= 0, state <= IDLE, weight_addr <= 0
- Latency: start edge to output update is exactly 18 clk cycles. busy is high in the cycles following edges 0 through 17.
- Outputs hold their values between commits and never show partial results.
- Inputs are sampled only at edge 0; later changes to sample_in* or jack do not affect the running computation.
- A rise at any edge where state = MAC, including edge 18, is ignored and sets overrun = 1. overrun clears only on reset.
- A rise at edge 19 or later, in IDLE, starts normally.
- Reset mid-operation aborts immediately:
  - no commit occurs, outputs = 0
  - the next start after release behaves as from reset.

Test Plan:
1. Identity: weights diag = 4096, others 0; inputs 100, -200, 300, -400; jack = 0x0F; start → outputs 100, -200, 300, -400 exactly 18 cycles after the start edge; busy high for 18 cycles; weight_addr sweeps 0..15.
2. Jack mask: all weights 4096; all inputs 1000; jack = 0x01 → every output = 1000; with jack = 0x00 → every output = 0.
3. Saturation: all weights 0x7FFF, all inputs 30000 → all outputs 32767; all inputs -30000 → all outputs -32768.
4. Rounding: W[0][0] = 2048, others 0; in0 = 3 → out0 = 2; in0 = -3 → out0 = -1; in0 = 1 → out0 = 1.
5. Overrun: second rise 10 cycles after the start → ignored; overrun = 1; outputs equal the first computation only; a rise 20 cycles after the first start runs normally and overrun stays 1.
6. Reset mid-op: assert rst 8 cycles after the start with sample_clk held high through release → outputs = 0, busy = 0, weight_addr = 0, overrun = 0; no start until sample_clk goes 0→1.
